// File: rtl/zanagotchi_pkg.sv
// Shared types and constants for the Zanagotchi pet engine: state codes,
// per-state attribute steps, saturating arithmetic and the OLED init list.
package zanagotchi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'b0000,
        ST_COMENDO    = 4'b0001,
        ST_DORMINDO   = 4'b0010,
        ST_DANDO_AULA = 4'b0011,
        ST_MORTO      = 4'b0100
    } state_t;

    typedef enum logic [1:0] {D_RESET, D_GAP, D_LOW, D_HIGH} disp_t;

    typedef struct packed {
        logic [7:0] fome_up, fome_dn, sono_up, sono_dn, feli_up, feli_dn;
    } delta_t;

    localparam logic [7:0] EAT_GAIN   = 8'd5;
    localparam logic [7:0] SLEEP_GAIN = 8'd5;
    localparam logic [7:0] TEACH_GAIN = 8'd3;
    localparam int         INIT_LEN   = 12;

    function automatic delta_t delta_for(input state_t s);
        delta_t d;
        d = '0;
        case (s)
            ST_IDLE:       begin d.fome_dn = 8'd2; d.sono_dn = 8'd1; d.feli_dn = 8'd1; end
            ST_COMENDO:    begin d.fome_up = EAT_GAIN; d.sono_dn = 8'd1; d.feli_dn = 8'd1; end
            ST_DORMINDO:   begin d.sono_up = SLEEP_GAIN; d.fome_dn = 8'd1; d.feli_dn = 8'd1; end
            ST_DANDO_AULA: begin d.feli_up = TEACH_GAIN; d.fome_dn = 8'd2; d.sono_dn = 8'd2; end
            default:       d = '0;
        endcase
        return d;
    endfunction

    // Each state only moves an attribute one way, so clamping the rise before
    // applying the fall is equivalent to either order.
    function automatic logic [7:0] sat_step(input logic [7:0] v, input logic [7:0] up,
                                            input logic [7:0] dn, input logic [7:0] top);
        logic [8:0] t;
        t = {1'b0, v} + {1'b0, up};
        if (t > {1'b0, top}) t = {1'b0, top};
        if (t < {1'b0, dn}) t = 9'd0;
        else                t = t - {1'b0, dn};
        return t[7:0];
    endfunction

    function automatic logic [7:0] init_cmd(input logic [3:0] idx);
        logic [7:0] c;
        case (idx)
            4'd0:  c = 8'hAE;
            4'd1:  c = 8'h20;
            4'd2:  c = 8'h00;
            4'd3:  c = 8'h21;
            4'd4:  c = 8'h00;
            4'd5:  c = 8'h7F;
            4'd6:  c = 8'h22;
            4'd7:  c = 8'h00;
            4'd8:  c = 8'h07;
            4'd9:  c = 8'h8D;
            4'd10: c = 8'h14;
            4'd11: c = 8'hAF;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/zanagotchi_if.sv
// Write-only SPI link to the SSD1306-style OLED panel.
interface zanagotchi_if;
    logic io_sclk;
    logic io_sdin;
    logic io_cs;
    logic io_dc;
    logic io_reset;

    modport master (output io_sclk, io_sdin, io_cs, io_dc, io_reset);
    modport slave  (input  io_sclk, io_sdin, io_cs, io_dc, io_reset);
endinterface

// File: rtl/zanagotchi_sprites.sv
// Combinational 128x64 image ROM, one picture per pet state.
// Byte index is page-major: page = index[9:7], column = index[6:0], LSB = top row.
module zanagotchi_sprites
    import zanagotchi_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic [9:0] i_index,
    output logic [7:0] o_byte
);
    logic [2:0] w_page;
    logic [6:0] w_col;

    assign w_page = i_index[9:7];
    assign w_col  = i_index[6:0];

    always_comb begin
        o_byte = 8'h00;
        case (i_state)
            ST_IDLE:     o_byte = w_col[0] ? 8'hAA : 8'h55;
            ST_COMENDO:  if (w_col >= 7'd32 && w_col < 7'd96 && w_page >= 3'd2 && w_page < 3'd6)
                             o_byte = 8'hFF;
            ST_DORMINDO: if (w_col[3:0] == 4'd0) o_byte = 8'hFF;
            ST_DANDO_AULA: begin
                if (w_col == 7'd0 || w_col == 7'd127) o_byte = 8'hFF;
                else if (w_page == 3'd0)              o_byte = 8'h01;
                else if (w_page == 3'd7)              o_byte = 8'h80;
            end
            ST_MORTO:    if (w_col[6:4] == w_page) o_byte = 8'hFF;
            default:     o_byte = 8'h00;
        endcase
    end
endmodule

// File: rtl/zanagotchi_core.sv
// Virtual-pet engine: button-driven activity FSM, once-per-second attribute
// updates with sticky death, and a continuous SPI frame streamer for the OLED.
module zanagotchi_core
    import zanagotchi_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int ATTR_INIT     = 50,
    parameter int ATTR_MAX      = 100,
    parameter int SPI_DIV       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        b1,
    input  logic        b2,
    output logic [3:0]  estado,
    output logic [7:0]  fome,
    output logic [7:0]  sono,
    output logic [7:0]  felicidade,
    output logic        morreu,
    zanagotchi_if.master oled
);
    localparam int         SEC_W     = $clog2(TICKS_PER_SEC);
    localparam logic [7:0] DIV_LAST  = 8'(SPI_DIV - 1);
    localparam logic [3:0] INIT_LAST = 4'(INIT_LEN - 1);

    state_t             r_estado, w_estado_next, w_btn_state, r_frame_state, w_frame_state_next;
    logic [1:0]         r_prev, w_code;
    logic [SEC_W-1:0]   r_sec_cnt;
    logic [7:0]         r_fome, r_sono, r_feli, w_fome_upd, w_sono_upd, w_feli_upd;
    logic               r_morreu, w_event, w_tick, w_live, w_fatal;
    delta_t             w_delta;

    disp_t              r_dstate, w_dstate_next;
    logic [1:0]         r_rcnt, w_rcnt_next;
    logic [7:0]         r_div, w_div_next, r_shift, w_shift_next, w_sprite_byte;
    logic [2:0]         r_bit, w_bit_next;
    logic [3:0]         r_cmd_idx, w_cmd_idx_next;
    logic [9:0]         r_pix_idx, w_pix_idx_next;
    logic               r_dc, w_dc_next, r_in_frame, w_in_frame_next;
    logic [3:0]         w_sprite_state;

    always_comb begin
        w_code      = {b1, b2};
        w_event     = (w_code != r_prev) && (w_code != 2'b00);
        w_tick      = (r_sec_cnt == SEC_W'(TICKS_PER_SEC - 1));
        w_btn_state = r_estado;
        if (w_event) begin
            case (r_estado)
                ST_IDLE: case (w_code)
                    2'b10:   w_btn_state = ST_COMENDO;
                    2'b01:   w_btn_state = ST_DORMINDO;
                    2'b11:   w_btn_state = ST_DANDO_AULA;
                    default: w_btn_state = r_estado;
                endcase
                ST_COMENDO:    if (w_code == 2'b10) w_btn_state = ST_IDLE;
                ST_DORMINDO:   if (w_code == 2'b01) w_btn_state = ST_IDLE;
                ST_DANDO_AULA: if (w_code == 2'b11) w_btn_state = ST_IDLE;
                default:       w_btn_state = r_estado;
            endcase
        end
        w_delta    = delta_for(r_estado);
        w_fome_upd = sat_step(r_fome, w_delta.fome_up, w_delta.fome_dn, 8'(ATTR_MAX));
        w_sono_upd = sat_step(r_sono, w_delta.sono_up, w_delta.sono_dn, 8'(ATTR_MAX));
        w_feli_upd = sat_step(r_feli, w_delta.feli_up, w_delta.feli_dn, 8'(ATTR_MAX));
        w_live     = w_tick && (r_estado != ST_MORTO);
        w_fatal    = w_live && (w_fome_upd == 8'd0 || w_sono_upd == 8'd0 || w_feli_upd == 8'd0);
        // Death overrides any button event landing on the same edge.
        w_estado_next = w_fatal ? ST_MORTO : w_btn_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado  <= ST_IDLE;
            r_prev    <= 2'b00;
            r_sec_cnt <= '0;
            r_fome    <= 8'(ATTR_INIT);
            r_sono    <= 8'(ATTR_INIT);
            r_feli    <= 8'(ATTR_INIT);
            r_morreu  <= 1'b0;
        end else begin
            r_estado  <= w_estado_next;
            r_prev    <= w_code;
            r_sec_cnt <= w_tick ? '0 : r_sec_cnt + 1'b1;
            if (w_live) begin
                r_fome <= w_fome_upd;
                r_sono <= w_sono_upd;
                r_feli <= w_feli_upd;
            end
            r_morreu  <= r_morreu | w_fatal;
        end
    end

    // The image for a frame is chosen from the live state only at byte 0.
    assign w_sprite_state = (r_pix_idx == 10'd0) ? r_estado : r_frame_state;

    zanagotchi_sprites u_sprites (
        .i_state (w_sprite_state),
        .i_index (r_pix_idx),
        .o_byte  (w_sprite_byte)
    );

    always_comb begin
        w_dstate_next      = r_dstate;
        w_rcnt_next        = r_rcnt;
        w_div_next         = r_div;
        w_bit_next         = r_bit;
        w_shift_next       = r_shift;
        w_dc_next          = r_dc;
        w_cmd_idx_next     = r_cmd_idx;
        w_pix_idx_next     = r_pix_idx;
        w_in_frame_next    = r_in_frame;
        w_frame_state_next = r_frame_state;
        case (r_dstate)
            D_RESET: begin
                if (r_rcnt == 2'd3) w_dstate_next = D_GAP;
                else                w_rcnt_next   = r_rcnt + 2'd1;
            end
            D_GAP: begin
                w_shift_next  = r_in_frame ? w_sprite_byte : init_cmd(r_cmd_idx);
                w_dc_next     = r_in_frame;
                if (r_in_frame && r_pix_idx == 10'd0) w_frame_state_next = r_estado;
                w_bit_next    = 3'd0;
                w_div_next    = 8'd0;
                w_dstate_next = D_LOW;
            end
            D_LOW: begin
                if (r_div == DIV_LAST) begin
                    w_div_next    = 8'd0;
                    w_dstate_next = D_HIGH;
                end else begin
                    w_div_next = r_div + 8'd1;
                end
            end
            D_HIGH: begin
                if (r_div != DIV_LAST) begin
                    w_div_next = r_div + 8'd1;
                end else if (r_bit != 3'd7) begin
                    w_div_next    = 8'd0;
                    w_bit_next    = r_bit + 3'd1;
                    w_shift_next  = {r_shift[6:0], 1'b0};
                    w_dstate_next = D_LOW;
                end else begin
                    w_div_next    = 8'd0;
                    w_dstate_next = D_GAP;
                    if (r_in_frame)                  w_pix_idx_next  = r_pix_idx + 10'd1;
                    else if (r_cmd_idx == INIT_LAST) w_in_frame_next = 1'b1;
                    else                             w_cmd_idx_next  = r_cmd_idx + 4'd1;
                end
            end
            default: w_dstate_next = D_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dstate      <= D_RESET;
            r_rcnt        <= 2'd0;
            r_div         <= 8'd0;
            r_bit         <= 3'd0;
            r_shift       <= 8'd0;
            r_dc          <= 1'b0;
            r_cmd_idx     <= 4'd0;
            r_pix_idx     <= 10'd0;
            r_in_frame    <= 1'b0;
            r_frame_state <= ST_IDLE;
        end else begin
            r_dstate      <= w_dstate_next;
            r_rcnt        <= w_rcnt_next;
            r_div         <= w_div_next;
            r_bit         <= w_bit_next;
            r_shift       <= w_shift_next;
            r_dc          <= w_dc_next;
            r_cmd_idx     <= w_cmd_idx_next;
            r_pix_idx     <= w_pix_idx_next;
            r_in_frame    <= w_in_frame_next;
            r_frame_state <= w_frame_state_next;
        end
    end

    assign estado        = r_estado;
    assign fome          = r_fome;
    assign sono          = r_sono;
    assign felicidade    = r_feli;
    assign morreu        = r_morreu;
    assign oled.io_sclk  = (r_dstate == D_HIGH);
    assign oled.io_cs    = !(r_dstate == D_LOW || r_dstate == D_HIGH);
    assign oled.io_sdin  = (r_dstate == D_LOW || r_dstate == D_HIGH) && r_shift[7];
    assign oled.io_dc    = r_dc;
    assign oled.io_reset = (r_dstate != D_RESET);
endmodule

// File: tb/tb_zanagotchi_core.sv
// Scoreboard bench for zanagotchi_core: status and SPI expectations are queued
// by the stimulus and popped by independent monitors.
module tb_zanagotchi_core;
    localparam int T = 800;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b1 = 1'b0;
    logic       b2 = 1'b0;
    logic [3:0] estado;
    logic [7:0] fome, sono, felicidade;
    logic       morreu;

    zanagotchi_if oled ();

    zanagotchi_core #(.TICKS_PER_SEC(T), .ATTR_INIT(50), .ATTR_MAX(100), .SPI_DIV(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .b1         (b1),
        .b2         (b2),
        .estado     (estado),
        .fome       (fome),
        .sono       (sono),
        .felicidade (felicidade),
        .morreu     (morreu),
        .oled       (oled)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic [7:0] fo, so, fe;
        logic       dead;
        logic       chk_io;
        logic [4:0] io;
        int         tag;
    } exp_t;

    exp_t       st_q[$];
    logic [8:0] spi_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       chk_req = 1'b0;
    int         t = 0;
    int         tag_n = 0;

    task automatic cmp(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL status%0d %s actual=%0d required=%0d", tag, nm, act, exp);
        end
    endtask

    // Status monitor: one pop per request, sampled on the falling edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (chk_req) begin
            if (st_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL status_queue actual=empty required=entry");
            end else begin
                e = st_q.pop_front();
                cmp("estado", e.tag, 32'(estado), 32'(e.st));
                cmp("fome", e.tag, 32'(fome), 32'(e.fo));
                cmp("sono", e.tag, 32'(sono), 32'(e.so));
                cmp("felicidade", e.tag, 32'(felicidade), 32'(e.fe));
                cmp("morreu", e.tag, 32'(morreu), 32'(e.dead));
                if (e.chk_io)
                    cmp("io_rst_cs_sclk_dc_sdin", e.tag,
                        32'({oled.io_reset, oled.io_cs, oled.io_sclk, oled.io_dc, oled.io_sdin}), 32'(e.io));
                $display("status%0d t=%0d estado=%0d fome=%0d sono=%0d felicidade=%0d morreu=%0d",
                         e.tag, t, estado, fome, sono, felicidade, morreu);
            end
        end
    end

    // SPI monitor: shift in on sclk rising while cs is low, compare whole bytes.
    initial begin
        logic       prev_sclk, prev_cs;
        logic [7:0] sh;
        logic [8:0] e;
        int         nbits, nbytes, cs_hi;
        prev_sclk = 1'b0; prev_cs = 1'b1; sh = 8'h00;
        nbits = 0; nbytes = 0; cs_hi = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                nbits = 0; nbytes = 0; cs_hi = 0;
            end else begin
                if (!oled.io_cs && oled.io_sclk && !prev_sclk) begin
                    sh = {sh[6:0], oled.io_sdin};
                    nbits++;
                    if (nbits == 8) begin
                        if (spi_q.size() > 0) begin
                            e = spi_q.pop_front();
                            checks++;
                            if ({oled.io_dc, sh} !== e) begin
                                errors++;
                                $display("FAIL spi_byte%0d actual=dc%0d:%02h required=dc%0d:%02h",
                                         nbytes, oled.io_dc, sh, e[8], e[7:0]);
                            end else if (nbytes < 16 || nbytes % 256 == 0) begin
                                $display("spi byte%0d dc=%0d data=%02h", nbytes, oled.io_dc, sh);
                            end
                        end
                        nbits = 0;
                        nbytes++;
                    end
                end
                if (oled.io_cs && !prev_cs && nbits != 0) begin
                    checks++; errors++;
                    $display("FAIL spi_partial_byte actual=%0d_bits required=8", nbits);
                    nbits = 0;
                end
                if (oled.io_cs) begin
                    cs_hi++;
                end else if (prev_cs) begin
                    if (nbytes > 0 && spi_q.size() > 0) begin
                        checks++;
                        if (cs_hi != 1) begin
                            errors++;
                            $display("FAIL spi_cs_gap actual=%0d required=1", cs_hi);
                        end
                    end
                    cs_hi = 0;
                end
            end
            prev_sclk = oled.io_sclk;
            prev_cs   = oled.io_cs;
        end
    end

    // Independent pixel-level description of the IDLE and COMENDO images.
    function automatic logic [7:0] sprite_model(input int st, input int idx);
        logic [7:0] b;
        int x, y;
        b = 8'h00;
        x = idx % 128;
        for (int r = 0; r < 8; r++) begin
            y = (idx / 128) * 8 + r;
            case (st)
                0:       b[r] = ((x + y) % 2) == 0;
                1:       b[r] = (x >= 32 && x < 96 && y >= 16 && y < 48);
                default: b[r] = 1'b0;
            endcase
        end
        return b;
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic goto_t(input int target);
        if (target > t) cycles(target - t);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        t = 0;
    endtask

    task automatic expect_status(input logic [3:0] st, input int fo, input int so, input int fe,
                                 input logic dead, input logic chk_io, input logic [4:0] io);
        exp_t e;
        e.st = st; e.fo = 8'(fo); e.so = 8'(so); e.fe = 8'(fe);
        e.dead = dead; e.chk_io = chk_io; e.io = io; e.tag = tag_n++;
        st_q.push_back(e);
        chk_req = 1'b1;
        cycles(1);
        chk_req = 1'b0;
    endtask

    initial begin
        logic [7:0] init_list [12];
        init_list = '{8'hAE, 8'h20, 8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'h8D, 8'h14, 8'hAF};

        // Display phase: init list, an IDLE frame, then a COMENDO frame.
        @(posedge clk); #1;
        do_reset();
        foreach (init_list[i]) spi_q.push_back({1'b0, init_list[i]});
        for (int i = 0; i < 1024; i++) spi_q.push_back({1'b1, sprite_model(0, i)});
        for (int i = 0; i < 1024; i++) spi_q.push_back({1'b1, sprite_model(1, i)});
        expect_status(4'b0000, 50, 50, 50, 1'b0, 1'b1, 5'b01000);
        goto_t(3);
        expect_status(4'b0000, 50, 50, 50, 1'b0, 1'b1, 5'b01000);
        expect_status(4'b0000, 50, 50, 50, 1'b0, 1'b1, 5'b11000);
        goto_t(600);
        b1 = 1'b1; cycles(1); b1 = 1'b0;
        while (spi_q.size() != 0 && t < 36000) cycles(1);
        if (spi_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL spi_timeout actual=%0d_left required=0", spi_q.size());
            spi_q.delete();
        end
        goto_t(36100);
        expect_status(4'b0001, 100, 5, 5, 1'b0, 1'b0, 5'b00000);

        // Attribute phase.
        do_reset();
        expect_status(4'b0000, 50, 50, 50, 1'b0, 1'b1, 5'b01000);
        goto_t(3 * T);
        expect_status(4'b0000, 44, 47, 47, 1'b0, 1'b0, 5'b00000);
        b1 = 1'b1; cycles(1); b1 = 1'b0;
        expect_status(4'b0001, 44, 47, 47, 1'b0, 1'b0, 5'b00000);
        goto_t(6 * T);
        expect_status(4'b0001, 59, 44, 44, 1'b0, 1'b0, 5'b00000);
        b1 = 1'b1; cycles(1); b1 = 1'b0;
        expect_status(4'b0000, 59, 44, 44, 1'b0, 1'b0, 5'b00000);
        b2 = 1'b1; cycles(1); b2 = 1'b0;
        expect_status(4'b0010, 59, 44, 44, 1'b0, 1'b0, 5'b00000);
        goto_t(9 * T);
        expect_status(4'b0010, 56, 59, 41, 1'b0, 1'b0, 5'b00000);
        b2 = 1'b1; cycles(1);
        expect_status(4'b0000, 56, 59, 41, 1'b0, 1'b0, 5'b00000);
        b1 = 1'b1; cycles(1); b1 = 1'b0; b2 = 1'b0;
        expect_status(4'b0011, 56, 59, 41, 1'b0, 1'b0, 5'b00000);
        goto_t(15 * T);
        expect_status(4'b0011, 44, 47, 59, 1'b0, 1'b0, 5'b00000);
        b1 = 1'b1; b2 = 1'b1; cycles(1); b1 = 1'b0; b2 = 1'b0;
        expect_status(4'b0000, 44, 47, 59, 1'b0, 1'b0, 5'b00000);

        // Fatal tick coincides with a button event: death must win.
        goto_t(37 * T - 1);
        b1 = 1'b1;
        expect_status(4'b0000, 2, 26, 38, 1'b0, 1'b0, 5'b00000);
        b1 = 1'b0;
        expect_status(4'b0100, 0, 25, 37, 1'b1, 1'b0, 5'b00000);
        b1 = 1'b1; cycles(1); b1 = 1'b0;
        b2 = 1'b1; cycles(1); b2 = 1'b0;
        b1 = 1'b1; b2 = 1'b1; cycles(1); b1 = 1'b0; b2 = 1'b0;
        goto_t(38 * T + 5);
        expect_status(4'b0100, 0, 25, 37, 1'b1, 1'b0, 5'b00000);
        do_reset();
        expect_status(4'b0000, 50, 50, 50, 1'b0, 1'b1, 5'b01000);

        cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
